// File: rtl/me_control.sv
// Full-search motion-estimation sequencer: walks every candidate, drives PE clears/ready strobes and pixel addresses.
// Latency: all outputs registered; 1 INIT cycle + NUM_ROWS*(BLK*BLK+NUM_PE) RUN cycles per search, o_done one cycle after.
// Backpressure: none; i_start is sampled only in IDLE/HOLD. Optional abort input is enabled by macro ME_CTRL_ABORT_EN.
module me_control #(
  parameter int NUM_PE   = 16,
  parameter int NUM_ROWS = 16,
  parameter int BLK      = 16,
  parameter int ADDR_R_W = 8,
  parameter int ADDR_S_W = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef ME_CTRL_ABORT_EN
  input  logic                i_abort,
`endif
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_CompStart,
  output logic [NUM_PE-1:0]   o_PEclr,
  output logic [NUM_PE-1:0]   o_PEready,
  output logic [7:0]          o_vectorX,
  output logic [7:0]          o_vectorY,
  output logic [ADDR_R_W-1:0] o_AddressR,
  output logic [ADDR_S_W-1:0] o_AddressS
);

  // Pixels per candidate, row length including the PE drain, and search window row width.
  localparam int NPIX = BLK * BLK;
  localparam int L    = NPIX + NUM_PE;
  localparam int SW   = BLK + NUM_PE - 1;
  localparam int TW   = $clog2(L);
  localparam int YW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DONE,
    HOLD
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [TW-1:0] t;
  logic [TW-1:0] nextT;
  logic [YW-1:0] y;
  logic [YW-1:0] nextY;
  logic          abortReq;

  int nTi;
  int nYi;

  logic [NUM_PE-1:0]   clrNext;
  logic [NUM_PE-1:0]   readyNext;
  logic [7:0]          vxNext;
  logic [7:0]          vyNext;
  logic [ADDR_R_W-1:0] addrRNext;
  logic [ADDR_S_W-1:0] addrSNext;

`ifdef ME_CTRL_ABORT_EN
  assign abortReq = i_abort;
`else
  assign abortReq = 1'b0;
`endif

  assign nTi = int'(nextT);
  assign nYi = int'(nextY);

  // Next state and next candidate position (row y, row-time t).
  always_comb begin
    nextState = state;
    nextT     = '0;
    nextY     = '0;
    case (state)
      IDLE: begin
        if (i_start) nextState = INIT;
      end
      INIT: begin
        // Counters are already zero here; the first RUN cycle is (0,0).
        if (abortReq) nextState = IDLE;
        else          nextState = RUN;
      end
      RUN: begin
        if (abortReq) begin
          nextState = IDLE;
        end else if (t == TW'(L - 1)) begin
          if (y == YW'(NUM_ROWS - 1)) begin
            nextState = DONE;
          end else begin
            nextY = y + YW'(1);
          end
        end else begin
          nextT = t + TW'(1);
          nextY = y;
        end
      end
      DONE: begin
        nextState = HOLD;
      end
      HOLD: begin
        // Abort wins over start here: the held comparator result is kept.
        if (i_start && !abortReq) nextState = INIT;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath strobes, candidate vector and addresses for the upcoming RUN position.
  always_comb begin
    clrNext   = '0;
    readyNext = '0;
    vxNext    = '0;
    vyNext    = '0;
    addrRNext = '0;
    addrSNext = '0;
    if (nextState == RUN) begin
      // PE k starts its accumulation window at t==k.
      if (nTi < NUM_PE) clrNext = NUM_PE'(1) << nTi;
      if (nTi < NPIX) begin
        addrRNext = ADDR_R_W'(nTi);
        addrSNext = ADDR_S_W'((nYi + nTi / BLK) * SW + nTi % BLK);
      end else begin
        // Drain: PE k finishes k cycles after the last reference pixel.
        readyNext = NUM_PE'(1) << (nTi - NPIX);
        vxNext    = 8'(nTi - NPIX - NUM_PE / 2);
        vyNext    = 8'(nYi - NUM_ROWS / 2);
      end
    end
  end

  // State, counters and every output register; outputs reflect the state being entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      t           <= '0;
      y           <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_CompStart <= 1'b0;
      o_PEclr     <= '0;
      o_PEready   <= '0;
      o_vectorX   <= '0;
      o_vectorY   <= '0;
      o_AddressR  <= '0;
      o_AddressS  <= '0;
    end else begin
      state       <= nextState;
      t           <= nextT;
      y           <= nextY;
      o_busy      <= (nextState == INIT) || (nextState == RUN);
      o_done      <= (nextState == DONE);
      // Comparator is cleared only during INIT so its result survives DONE and HOLD.
      o_CompStart <= (nextState == RUN) || (nextState == DONE) || (nextState == HOLD);
      o_PEclr     <= clrNext;
      o_PEready   <= readyNext;
      o_vectorX   <= vxNext;
      o_vectorY   <= vyNext;
      o_AddressR  <= addrRNext;
      o_AddressS  <= addrSNext;
    end
  end

endmodule

// File: tb/tb_me_control.sv
// Directed bench for me_control: vector table over one search, plus back-to-back, reset and abort sequences.
// Outputs sampled 1 time unit after the rising edge; a negedge monitor accumulates strobe counts.
// Define ME_CTRL_ABORT_EN for both files to exercise the abort input.
module tb_me_control;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        compStart;
  logic [15:0] peClr;
  logic [15:0] peReady;
  logic [7:0]  vecX;
  logic [7:0]  vecY;
  logic [7:0]  addrR;
  logic [9:0]  addrS;
`ifdef ME_CTRL_ABORT_EN
  logic        abort;
`endif

  int passCnt = 0;
  int totalCnt = 0;

  // Running totals from the monitor; the main flow only takes differences.
  int rdyCnt = 0;
  int busyCnt = 0;
  int doneCnt = 0;
  int ohErr = 0;

  me_control dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef ME_CTRL_ABORT_EN
    .i_abort    (abort),
`endif
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_CompStart(compStart),
    .o_PEclr    (peClr),
    .o_PEready  (peReady),
    .o_vectorX  (vecX),
    .o_vectorY  (vecY),
    .o_AddressR (addrR),
    .o_AddressS (addrS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (peReady != 16'h0) rdyCnt++;
      if (busy) busyCnt++;
      if (done) doneCnt++;
      if ($countones(peReady) > 1 || $countones(peClr) > 1) ohErr++;
    end
  end

  typedef struct {
    int          idx;   // RUN cycle index = y*272 + t
    logic [15:0] clr;
    logic [15:0] rdy;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [7:0]  ar;
    logic [9:0]  as;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkZero(input string tag);
    chk({tag, " busy"},  32'(busy), 32'h0);
    chk({tag, " done"},  32'(done), 32'h0);
    chk({tag, " cs"},    32'(compStart), 32'h0);
    chk({tag, " clr"},   32'(peClr), 32'h0);
    chk({tag, " rdy"},   32'(peReady), 32'h0);
    chk({tag, " vx"},    32'(vecX), 32'h0);
    chk({tag, " vy"},    32'(vecY), 32'h0);
    chk({tag, " addrR"}, 32'(addrR), 32'h0);
    chk({tag, " addrS"}, 32'(addrS), 32'h0);
  endtask

  initial begin
    int cur;
    int snapRdy;
    int snapBusy;
    int snapDone;
    int doneAt;
    int csLow;
    string nm;

    // idx, clr, rdy, vx, vy, addrR, addrS  (SW = 31)
    vecs[0]  = '{0,    16'h0001, 16'h0000, 8'h00, 8'h00, 8'd0,   10'd0};
    vecs[1]  = '{15,   16'h8000, 16'h0000, 8'h00, 8'h00, 8'd15,  10'd15};
    vecs[2]  = '{16,   16'h0000, 16'h0000, 8'h00, 8'h00, 8'd16,  10'd31};
    vecs[3]  = '{255,  16'h0000, 16'h0000, 8'h00, 8'h00, 8'd255, 10'd480};
    vecs[4]  = '{256,  16'h0000, 16'h0001, 8'hF8, 8'hF8, 8'd0,   10'd0};
    vecs[5]  = '{271,  16'h0000, 16'h8000, 8'h07, 8'hF8, 8'd0,   10'd0};
    vecs[6]  = '{272,  16'h0001, 16'h0000, 8'h00, 8'h00, 8'd0,   10'd31};
    vecs[7]  = '{833,  16'h0000, 16'h0000, 8'h00, 8'h00, 8'd17,  10'd125};
    vecs[8]  = '{1072, 16'h0000, 16'h0001, 8'hF8, 8'hFB, 8'd0,   10'd0};
    vecs[9]  = '{4335, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'd255, 10'd945};
    vecs[10] = '{4351, 16'h0000, 16'h8000, 8'h07, 8'h07, 8'd0,   10'd0};

    rst = 1'b1;
    start = 1'b0;
`ifdef ME_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle for 10 cycles: everything stays quiet.
    repeat (10) tick();
    checkZero("idle");

    // One full search checked against the vector table.
    snapRdy = rdyCnt; snapBusy = busyCnt; snapDone = doneCnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("init busy", 32'(busy), 32'h1);
    chk("init cs",   32'(compStart), 32'h0);
    chk("init clr",  32'(peClr), 32'h0);
    cur = -1;
    for (int i = 0; i < 11; i++) begin
      while (cur < vecs[i].idx) begin
        tick();
        cur++;
      end
      nm = $sformatf("v%0d", vecs[i].idx);
      chk({nm, " busy"},  32'(busy), 32'h1);
      chk({nm, " cs"},    32'(compStart), 32'h1);
      chk({nm, " clr"},   32'(peClr), 32'(vecs[i].clr));
      chk({nm, " rdy"},   32'(peReady), 32'(vecs[i].rdy));
      chk({nm, " vx"},    32'(vecX), 32'(vecs[i].vx));
      chk({nm, " vy"},    32'(vecY), 32'(vecs[i].vy));
      chk({nm, " addrR"}, 32'(addrR), 32'(vecs[i].ar));
      chk({nm, " addrS"}, 32'(addrS), 32'(vecs[i].as));
    end
    tick();
    chk("done pulse", 32'(done), 32'h1);
    chk("done busy",  32'(busy), 32'h0);
    chk("done cs",    32'(compStart), 32'h1);
    chk("done rdy",   32'(peReady), 32'h0);
    tick();
    chk("hold done", 32'(done), 32'h0);
    chk("hold cs",   32'(compStart), 32'h1);
    chk("hold busy", 32'(busy), 32'h0);
    chk("busy cycles",   32'(busyCnt - snapBusy), 32'd4353);
    chk("ready strobes", 32'(rdyCnt - snapRdy), 32'd256);
    chk("done count",    32'(doneCnt - snapDone), 32'd1);
    repeat (3) tick();
    chk("hold stable cs", 32'(compStart), 32'h1);

    // Held i_start from HOLD: CompStart low only in INIT, RUN ignores start, back-to-back restart.
    start = 1'b1;
    tick();
    chk("b2b init cs",   32'(compStart), 32'h0);
    chk("b2b init busy", 32'(busy), 32'h1);
    doneAt = -1;
    csLow = 0;
    for (int n = 1; n <= 6000; n++) begin
      tick();
      if (!compStart) csLow++;
      if (done) begin
        doneAt = n;
        break;
      end
    end
    chk("b2b done latency", 32'(doneAt), 32'd4353);
    chk("b2b cs low in run", 32'(csLow), 32'd0);
    tick();
    chk("b2b hold cs",   32'(compStart), 32'h1);
    chk("b2b hold busy", 32'(busy), 32'h0);
    tick();
    chk("b2b reinit cs",   32'(compStart), 32'h0);
    chk("b2b reinit busy", 32'(busy), 32'h1);
    start = 1'b0;

    // Reset in the middle of RUN: outputs clear at once and no done follows.
    repeat (1000) tick();
    chk("pre-rst busy", 32'(busy), 32'h1);
    snapDone = doneCnt;
    rst = 1'b1;
    #1;
    checkZero("rst");
    tick();
    rst = 1'b0;
    repeat (4500) tick();
    checkZero("post-rst");
    chk("post-rst no done", 32'(doneCnt - snapDone), 32'd0);

`ifdef ME_CTRL_ABORT_EN
    // Abort in RUN returns to IDLE on the next cycle with no done.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1000) tick();
    snapDone = doneCnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkZero("abort");
    repeat (4500) tick();
    chk("abort no done", 32'(doneCnt - snapDone), 32'd0);
    chk("abort idle busy", 32'(busy), 32'h0);
`endif

    chk("one-hot strobes", 32'(ohErr), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
